// File: rtl/instr_decode_pipe.sv
// Purpose : two-stage instruction decoder with an NREG x XLEN register file and operand fetch.
// Latency : 2 cycles from input transfer to out_valid (S1 decode, S2 operand read).
// Backpr. : valid/ready; a stalled S2 holds its outputs, S1 fills behind it, then in_ready drops.
//
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready/komut           - instruction input handshake
//           wr_en/wr_addr/wr_data             - register-file write port
//           out_valid/out_ready               - decoded result handshake
//           opcode, aluop, rs1, rs2, rd, rs1_data, rs2_data, imm, hata, err_cnt
// Config  : define DEC_SIGN_EXT_EN to sign-extend immediates from komut[31]; otherwise zero-extend.
module instr_decode_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     komut,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [3:0]      aluop,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic            hata,
    output logic [7:0]      err_cnt
);

    localparam int         AW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG_W = 6'(NREG);

`ifdef DEC_SIGN_EXT_EN
    localparam logic SEXT = 1'b1;
`else
    localparam logic SEXT = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]      opcode;
        logic [3:0]      aluop;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            hata;
    } dec_t;

    // Widen a 32-bit immediate image to XLEN; the fill bit is the sign only when enabled.
    function automatic logic [XLEN-1:0] ext(input logic [31:0] v, input logic s);
        return XLEN'({{32{s}}, v});
    endfunction

    function automatic logic idx_bad(input logic [4:0] idx);
        return {1'b0, idx} >= NREG_W;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic            s1_vld_q, s2_vld_q;
    dec_t            s1_q, s2_q, dec_d, out_dec;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q, rs1_data_d, rs2_data_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic            s2_adv, s1_xfer, in_xfer, out_xfer, fill;

    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_xfer  = s1_vld_q && s2_adv;
    assign in_ready = !rst && (!s1_vld_q || s2_adv);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // ------------------------------------------------------------------
    // S1 decode (combinational on komut, registered on input transfer)
    // ------------------------------------------------------------------
    always_comb begin
        fill         = SEXT & komut[31];
        dec_d        = '0;
        dec_d.opcode = komut[6:0];
        case (komut[6:0])
            7'b0000001: begin
                dec_d.rs1   = komut[19:15];
                dec_d.rs2   = komut[24:20];
                dec_d.rd    = komut[11:7];
                dec_d.aluop = {komut[30], komut[14:12]};
            end
            7'b0000011: begin
                dec_d.rs1   = komut[19:15];
                dec_d.rd    = komut[11:7];
                dec_d.aluop = {1'b0, komut[14:12]};
                dec_d.imm   = ext({{20{fill}}, komut[31:20]}, fill);
            end
            7'b0000111: begin
                dec_d.rd    = komut[11:7];
                dec_d.imm   = ext({komut[31:12], 12'b0}, fill);
            end
            7'b0001111: begin
                dec_d.rs1   = komut[19:15];
                dec_d.rs2   = komut[24:20];
                dec_d.aluop = {1'b0, komut[14:12]};
                dec_d.imm   = ext({{19{fill}}, komut[31:25], komut[11:7], 1'b0}, fill);
            end
            default: dec_d.hata = 1'b1;
        endcase
        // Unused fields are zero here, so only real register references can flag.
        if (idx_bad(dec_d.rs1) || idx_bad(dec_d.rs2) || idx_bad(dec_d.rd)) begin
            dec_d.hata = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // S2 operand fetch with write-first bypass
    // ------------------------------------------------------------------
    always_comb begin
        rs1_data_d = '0;
        rs2_data_d = '0;
        if (s1_q.rs1 != 5'd0 && !idx_bad(s1_q.rs1)) begin
            if (wr_en && wr_addr == s1_q.rs1) rs1_data_d = wr_data;
            else                              rs1_data_d = rf_q[s1_q.rs1[AW-1:0]];
        end
        if (s1_q.rs2 != 5'd0 && !idx_bad(s1_q.rs2)) begin
            if (wr_en && wr_addr == s1_q.rs2) rs2_data_d = wr_data;
            else                              rs2_data_d = rf_q[s1_q.rs2[AW-1:0]];
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_xfer && s2_q.hata && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Register file: x0 and out-of-range indices are never stored
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en && wr_addr != 5'd0 && !idx_bad(wr_addr)) begin
            rf_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_q       <= '0;
            s2_vld_q   <= 1'b0;
            s2_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (in_xfer) begin
                s1_vld_q <= 1'b1;
                s1_q     <= dec_d;
            end else if (s1_xfer) begin
                s1_vld_q <= 1'b0;
            end
            if (s1_xfer) begin
                s2_vld_q   <= 1'b1;
                s2_q       <= s1_q;
                rs1_data_q <= rs1_data_d;
                rs2_data_q <= rs2_data_d;
            end else if (out_xfer) begin
                s2_vld_q <= 1'b0;
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    // Outputs read as zero during the reset cycle itself, not only after it.
    assign out_dec   = rst ? '0 : s2_q;
    assign out_valid = s2_vld_q && !rst;
    assign opcode    = out_dec.opcode;
    assign aluop     = out_dec.aluop;
    assign rs1       = out_dec.rs1;
    assign rs2       = out_dec.rs2;
    assign rd        = out_dec.rd;
    assign imm       = out_dec.imm;
    assign hata      = out_dec.hata;
    assign rs1_data  = rst ? '0 : rs1_data_q;
    assign rs2_data  = rst ? '0 : rs2_data_q;
    assign err_cnt   = rst ? '0 : err_cnt_q;

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data/immediate width (32 or 64).
REQ-002 Parameter NREG, default 32, SHALL set register-file depth (power of two, 2..32).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  komut valid; in_ready  out  1  block accepts komut.
REQ-006 komut  in  32  instruction word.
REQ-007 wr_en  in  1, wr_addr  in  5, wr_data  in  XLEN  register-file write port.
REQ-008 out_valid  out  1  decoded result valid; out_ready  in  1  consumer accepts.
REQ-009 opcode  out  7, aluop  out  4, rs1/rs2/rd  out  5 each  decoded fields.
REQ-010 rs1_data/rs2_data  out  XLEN  operand values; imm  out  XLEN  immediate.
REQ-011 hata  out  1  decode error; err_cnt  out  8  saturating error count.

Function
REQ-012 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer when out_valid and out_ready are both high.
REQ-013 Two stages: S1 registers komut and decodes; S2 reads register file and drives outputs; latency 2 cycles from input transfer to out_valid (out_ready held high).
REQ-014 in_ready SHALL be high when S1 is empty or S1 advances this cycle; S1 advances when S2 is empty or S2 transfers; throughput one instruction per cycle.
REQ-015 While out_valid and not out_ready, every output SHALL hold stable; no instruction dropped, duplicated or reordered.
REQ-016 opcode 0000001 (R): rs1=[19:15], rs2=[24:20], rd=[11:7], aluop={[30],[14:12]}, imm=0.
REQ-017 opcode 0000011 (I): rs1=[19:15], rd=[11:7], rs2=0, aluop={0,[14:12]}, imm=ext([31:20]).
REQ-018 opcode 0000111 (U): rd=[11:7], rs1=rs2=0, aluop=0, imm=ext({[31:12],12'b0}).
REQ-019 opcode 0001111 (B): rs1=[19:15], rs2=[24:20], rd=0, aluop={0,[14:12]}, imm=ext({[31:25],[11:7],1'b0}).
REQ-020 Any other opcode: hata=1; rs1, rs2, rd, aluop, imm, rs1_data, rs2_data all 0; opcode passes through.
REQ-021 Any used rs1/rs2/rd index >= NREG: hata=1, that register's data reads 0, other fields decoded normally.
REQ-022 Register file NREG x XLEN; index 0 reads 0; writes to index 0 or index >= NREG ignored.
REQ-023 Operands SHALL be sampled on the S1->S2 transfer and held; if wr_en writes the same nonzero index in that cycle, wr_data SHALL be returned (write-first).
REQ-024 Unused-register reads (rs=0 per decode) SHALL give 0.
REQ-025 err_cnt SHALL increment by 1 on each output transfer with hata=1, saturating at 255.

Reset
REQ-026 While rst is high: in_ready=0, out_valid=0, all data outputs 0, err_cnt=0, register file cleared to 0, writes ignored.
REQ-027 rst mid-operation SHALL discard all in-flight instructions; in_ready=1 the first cycle after rst falls.

Configuration
REQ-028 With DEC_SIGN_EXT_EN defined, ext() SHALL sign-extend from komut[31] to XLEN.
REQ-029 Without DEC_SIGN_EXT_EN, ext() SHALL zero-extend to XLEN; no other behaviour differs.

Verification
REQ-030 Write x10=0x5, x11=0x7; send 0x40B50501 -> after 2 cycles: aluop=1000, rs1=10, rs2=11, rd=10, rs1_data=5, rs2_data=7, imm=0, hata=0.
REQ-031 Send 0xFFF0A103 -> rs1=1, rd=2, aluop=0010, rs2=0; imm=0x00000FFF without macro, 0xFFFFFFFF with DEC_SIGN_EXT_EN (XLEN=32).
REQ-032 Send 0x00000000 three times, out_ready high -> hata=1 each, all fields 0, err_cnt ends at 3; 256 errors -> err_cnt stays 255.
REQ-033 out_ready low 5 cycles while 3 valid instructions offered -> two accepted, in_ready low, outputs stable; release -> all three emerge in order, back-to-back.
REQ-034 wr_en x5=0xDEAD in the S1->S2 cycle of an R instruction with rs1=5 -> rs1_data=0xDEAD; write to x0 -> reads 0; NREG=16, rs2=20 -> hata=1, rs2_data=0.
REQ-035 Assert rst one cycle with both stages full -> out_valid=0 next cycle, no stale output ever emerges, err_cnt=0, registers read 0.
